// File: rtl/relogio_pkg.sv
// Shared types and default timing constants for the clock mode/timing controller.
package relogio_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2
   } modo_t;

   localparam int TICK_DIV_DEF      = 50_000_000;
   localparam int BLINK_DIV_DEF     = 12_500_000;
   localparam int REPEAT_DELAY_DEF  = 25_000_000;
   localparam int REPEAT_PERIOD_DEF = 5_000_000;

   // Counter width for a divide-by-n counter, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ctrl_relogio_btn_repeat.sv
// Rising-edge detector with auto-repeat pulse train for a held button.
// enable=0 drops any train in progress; a new train needs a fresh edge.
module btn_repeat
   import relogio_pkg::*;
#(
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic enable,
   output logic pulse
);

   localparam int RW = cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [RW-1:0] DELAY_LD  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LD = RW'(REPEAT_PERIOD - 1);

   logic          btn_q;
   logic          active_q, active_d;
   logic [RW-1:0] rpt_q, rpt_d;
   logic          rise;
   logic          rpt_tc;

   assign rise   = btn & ~btn_q;
   assign rpt_tc = active_q & (rpt_q == '0);

   // Edge register resets high so a button held through reset gives no pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q    <= 1'b1;
         active_q <= 1'b0;
         rpt_q    <= '0;
      end else begin
         btn_q    <= btn;
         active_q <= active_d;
         rpt_q    <= rpt_d;
      end
   end

   always_comb begin
      active_d = active_q;
      rpt_d    = rpt_q;
      pulse    = 1'b0;
      if (!enable || !btn) begin
         active_d = 1'b0;
         rpt_d    = '0;
      end else if (rise) begin
         pulse    = 1'b1;
         active_d = 1'b1;
         rpt_d    = DELAY_LD;
      end else if (rpt_tc) begin
         pulse = 1'b1;
         rpt_d = PERIOD_LD;
      end else if (active_q) begin
         rpt_d = rpt_q - RW'(1);
      end
   end

endmodule

// File: rtl/ctrl_relogio.sv
// Mode and timing controller for the seconds/minutes/hours BCD chain.
//   state | meaning
//   RUN   | free-running 1 Hz tick, carries ripple into minutes/hours
//   SET_H | btn_inc (with auto-repeat) steps hours, hours digits blink
//   SET_M | btn_inc (with auto-repeat) steps minutes, minutes digits blink
module ctrl_relogio
   import relogio_pkg::*;
#(
   parameter int TICK_DIV      = TICK_DIV_DEF,
   parameter int BLINK_DIV     = BLINK_DIV_DEF,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       carry_s,
   input  logic       carry_m,
   output logic       en_s,
   output logic       inc_m,
   output logic       inc_h,
   output logic       clr_s,
   output logic       blink_m,
   output logic       blink_h,
   output logic [1:0] modo
);

   localparam int TW = cnt_w(TICK_DIV);
   localparam int BW = cnt_w(BLINK_DIV);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   modo_t         modo_q, modo_d;
   logic          btn_mode_q;
   logic          rise_mode;
   logic [TW-1:0] tick_q, tick_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic          clr_s_q, clr_s_d;
   logic          set_mode;
   logic          tick_tc;
   logic          rpt_en;
   logic          p;

   assign rise_mode = btn_mode & ~btn_mode_q;
   assign set_mode  = (modo_q == SET_H) || (modo_q == SET_M);
   assign tick_tc   = (tick_q == TICK_LAST);
   // A mode change in the same cycle as an inc edge swallows the increment.
   assign rpt_en    = set_mode & ~rise_mode;

   btn_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_rpt_inc (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn_inc),
      .enable (rpt_en),
      .pulse  (p)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         modo_q     <= RUN;
         btn_mode_q <= 1'b1;
         tick_q     <= '0;
         blink_q    <= '0;
         phase_q    <= 1'b0;
         clr_s_q    <= 1'b0;
      end else begin
         modo_q     <= modo_d;
         btn_mode_q <= btn_mode;
         tick_q     <= tick_d;
         blink_q    <= blink_d;
         phase_q    <= phase_d;
         clr_s_q    <= clr_s_d;
      end
   end

   always_comb begin
      modo_d = modo_q;
      case (modo_q)
         RUN:     if (rise_mode) modo_d = SET_H;
         SET_H:   if (rise_mode) modo_d = SET_M;
         SET_M:   if (rise_mode) modo_d = RUN;
         default: modo_d = RUN;
      endcase
   end

   // Tick counter is zeroed on any mode change so RUN always restarts a full second.
   always_comb begin
      tick_d = '0;
      if ((modo_q == RUN) && !rise_mode) begin
         tick_d = tick_tc ? '0 : tick_q + TW'(1);
      end
      blink_d = '0;
      phase_d = 1'b0;
      if (set_mode && !rise_mode) begin
         if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
         end else begin
            blink_d = blink_q + BW'(1);
            phase_d = phase_q;
         end
      end
      clr_s_d = (modo_q == SET_M) & rise_mode;
   end

   always_comb begin
      en_s    = 1'b0;
      inc_m   = 1'b0;
      inc_h   = 1'b0;
      blink_m = 1'b0;
      blink_h = 1'b0;
      case (modo_q)
         RUN: begin
            en_s  = tick_tc;
            inc_m = tick_tc & carry_s;
            inc_h = tick_tc & carry_s & carry_m;
         end
         SET_H: begin
            inc_h   = p;
            blink_h = phase_q & ~btn_inc;
         end
         SET_M: begin
            inc_m   = p;
            blink_m = phase_q & ~btn_inc;
         end
         default: ;
      endcase
   end

   assign clr_s = clr_s_q;
   assign modo  = modo_q;

endmodule
